muldiv_unit: RTL and testbench

Parametrised iterative RV32M multiply/divide unit attached to the EX stage of the 5-stage pipeline. It gives the pipeline a multi-cycle execution mode: it accepts one operation, asserts `busy` so the hazard logic stalls IF/ID/EX, and returns a tagged result with a one-cycle `done` pulse for the EX/MEM register. Width is set by `XLEN`. Special division cases complete on a fast path.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_ADJ  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_t;

    function automatic logic is_div(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

    function automatic logic is_rem(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM) || (f3 == F3_MULH) || (f3 == F3_MULHSU);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM) || (f3 == F3_MULH);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes,
// sign fix-up in ADJ, fast path for divide-by-zero and signed overflow.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [TAG_W-1:0] rd_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] rd_out
);

    localparam int unsigned AW = 2 * XLEN;
    localparam int unsigned SW = XLEN + 1;

    muldiv_state_t    r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [TAG_W-1:0] r_tag;
    logic             r_neg;
    logic [AW-1:0]    r_acc;
    logic [XLEN-1:0]  r_b;
    logic             r_busy, r_done;
    logic [XLEN-1:0]  r_result;
    logic [TAG_W-1:0] r_rd_out;

    logic             w_sign_a, w_sign_b, w_div_zero, w_ovf, w_fast, w_accept;
    logic [XLEN-1:0]  w_acc_hi, w_acc_lo, w_mag_a, w_mag_b, w_div_sel;
    logic [XLEN-1:0]  w_fast_result, w_adj_result;
    logic [AW-1:0]    w_neg_in, w_neg_out, w_mul_full, w_acc_step;
    logic [SW-1:0]    w_add_a, w_add_b, w_mul_hi;
    logic             w_add_cin, w_div_ge;
    logic [SW:0]      w_sum;

    assign w_acc_hi   = r_acc[AW-1:XLEN];
    assign w_acc_lo   = r_acc[XLEN-1:0];
    assign w_sign_a   = is_signed_a(funct3) & rs1_data[XLEN-1];
    assign w_sign_b   = is_signed_b(funct3) & rs2_data[XLEN-1];
    assign w_div_zero = is_div(funct3) && (rs2_data == '0);
    assign w_ovf      = ((funct3 == F3_DIV) || (funct3 == F3_REM))
                        && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    assign w_fast     = w_div_zero | w_ovf;
    assign w_accept   = (r_state == S_IDLE) && start && !flush;
    assign w_div_sel  = is_rem(r_op) ? w_acc_hi : w_acc_lo;

    // Shared negator: |rs1| while idle, signed fix-up of the raw result in ADJ.
    always_comb begin
        w_neg_in = '0;
        if (r_state == S_IDLE)
            w_neg_in = AW'(rs1_data);
        else if (is_div(r_op))
            w_neg_in = AW'(w_div_sel);
        else
            w_neg_in = r_acc;
    end
    assign w_neg_out = (~w_neg_in) + AW'(1);
    assign w_mag_a   = w_sign_a ? w_neg_out[XLEN-1:0] : rs1_data;

    // Shared adder/subtractor: 0-rs2 while idle, trial subtract or partial-product add in CALC.
    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        if (r_state == S_IDLE) begin
            w_add_b   = ~{1'b0, rs2_data};
            w_add_cin = 1'b1;
        end else if (is_div(r_op)) begin
            w_add_a   = {w_acc_hi, w_acc_lo[XLEN-1]};
            w_add_b   = ~{1'b0, r_b};
            w_add_cin = 1'b1;
        end else begin
            w_add_a   = {1'b0, w_acc_hi};
            w_add_b   = {1'b0, r_b};
        end
    end
    assign w_sum    = {1'b0, w_add_a} + {1'b0, w_add_b} + (SW+1)'(w_add_cin);
    assign w_mag_b  = w_sign_b ? w_sum[XLEN-1:0] : rs2_data;
    assign w_div_ge = w_sum[SW];

    // One iteration: restoring divide step or shift-add multiply step.
    always_comb begin
        w_mul_hi   = w_acc_lo[0] ? w_sum[XLEN:0] : {1'b0, w_acc_hi};
        w_acc_step = {w_mul_hi, w_acc_lo[XLEN-1:1]};
        if (is_div(r_op))
            w_acc_step = {(w_div_ge ? w_sum[XLEN-1:0] : w_add_a[XLEN-1:0]),
                          w_acc_lo[XLEN-2:0], w_div_ge};
    end

    always_comb begin
        w_mul_full = r_neg ? w_neg_out : r_acc;
        if (is_div(r_op))
            w_adj_result = r_neg ? w_neg_out[XLEN-1:0] : w_div_sel;
        else if (r_op == F3_MUL)
            w_adj_result = w_mul_full[XLEN-1:0];
        else
            w_adj_result = w_mul_full[AW-1:XLEN];
    end

    always_comb begin
        if (w_div_zero)
            w_fast_result = is_rem(funct3) ? rs1_data : '1;
        else
            w_fast_result = is_rem(funct3) ? '0 : rs1_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = w_fast ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush)
                    w_next_state = S_IDLE;
                else if (r_cnt == CNT_W'(1))
                    w_next_state = S_ADJ;
            end
            S_ADJ:  w_next_state = flush ? S_IDLE : S_DONE;
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // busy stays up through the done cycle so it drops together with done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_tag    <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_b      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            r_busy <= (w_next_state != S_IDLE) || (r_state == S_DONE);
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= funct3;
                        r_tag <= rd_in;
                        r_cnt <= w_fast ? '0 : CNT_W'(XLEN);
                        r_neg <= is_rem(funct3) ? w_sign_a : (w_sign_a ^ w_sign_b);
                        if (is_div(funct3)) begin
                            r_acc <= AW'(w_mag_a);
                            r_b   <= w_mag_b;
                        end else begin
                            r_acc <= AW'(w_mag_b);
                            r_b   <= w_mag_a;
                        end
                        if (w_fast) begin
                            r_result <= w_fast_result;
                            r_rd_out <= rd_in;
                        end
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        r_acc <= w_acc_step;
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_ADJ: begin
                    if (!flush) begin
                        r_result <= w_adj_result;
                        r_rd_out <= r_tag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign rd_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences
// and randomized operations checked against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;
    localparam int LAT_NORMAL = XLEN + 2;
    localparam int LAT_FAST   = 1;
    localparam int TIMEOUT    = 100;

    logic             clk = 1'b0;
    logic             reset, start, flush;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  rs1_data, rs2_data;
    logic [TAG_W-1:0] rd_in;
    logic             busy, done;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .flush(flush),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       f3;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  exp;
        int               lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'd0, b});
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub); return p[63:32]; end
            3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'(sa / sb);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        if (f3[2] && (b == 0)) return LAT_FAST;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return LAT_FAST;
        return LAT_NORMAL;
    endfunction

    // Entered and left #1 after a rising edge; start is sampled at the first edge.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic [31:0] res,
                          output logic [4:0] rtag, output int lat);
        funct3 = f3; rs1_data = a; rs2_data = b; rd_in = tag; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rs1_data = $urandom; rs2_data = $urandom;
        funct3 = 3'($urandom); rd_in = 5'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < TIMEOUT);
        if (!done) lat = -1;
        res  = result;
        rtag = rd_out;
    endtask

    task automatic expect_quiet(input string name, input int n);
        int seen = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, exp_res, last_exp;
        logic [4:0]  rtag;
        int          lat;

        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, LAT_NORMAL};
        vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, LAT_NORMAL};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF, LAT_NORMAL};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, LAT_NORMAL};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, LAT_NORMAL};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, LAT_NORMAL};
        vecs[6]  = '{3'b101, 32'd100,        32'd7,         5'd11, 32'd14,        LAT_NORMAL};
        vecs[7]  = '{3'b111, 32'd100,        32'd7,         5'd12, 32'd2,         LAT_NORMAL};
        vecs[8]  = '{3'b101, 32'd123,        32'd0,         5'd13, 32'hFFFF_FFFF, LAT_FAST};
        vecs[9]  = '{3'b110, 32'd123,        32'd0,         5'd14, 32'd123,       LAT_FAST};
        vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, LAT_FAST};
        vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd31, 32'd0,         LAT_FAST};

        reset = 1'b0; start = 1'b0; flush = 1'b0;
        funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_done",   32'(done),   32'd0);
        check("reset_result", result,      32'd0);
        check("reset_rd_out", 32'(rd_out), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].tag, res, rtag, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_rd_out", i), 32'(rtag), 32'(vecs[i].tag));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_busy_fall", i), 32'(busy), 32'd0);
        end
        last_exp = vecs[11].exp;

        // start held during CALC with different operands must not disturb the op
        exp_res = model(3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
        funct3 = 3'b011; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h1234_5678; rd_in = 5'd3;
        start = 1'b1;
        @(posedge clk); #1;
        funct3 = 3'b100; rs1_data = 32'd55; rs2_data = 32'd0; rd_in = 5'd20;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 15) start = 1'b0;
        end while (!done && lat < TIMEOUT);
        start = 1'b0;
        if (!done) lat = -1;
        check("start_ignored_result",  result,      exp_res);
        check("start_ignored_rd_out",  32'(rd_out), 32'd3);
        check("start_ignored_latency", 32'(lat),    32'(LAT_NORMAL));
        last_exp = exp_res;
        repeat (2) @(posedge clk);
        #1;

        // flush sampled at CALC cycle 10
        funct3 = 3'b101; rs1_data = 32'd999; rs2_data = 32'd13; rd_in = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy_low", 32'(busy), 32'd0);
        expect_quiet("flush_no_done", 40);
        check("flush_result_held", result, last_exp);

        // flush and start together in idle
        funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd4; rd_in = 5'd9;
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);
        expect_quiet("flush_start_no_done", 40);

        // asynchronous reset at CALC cycle 5
        funct3 = 3'b001; rs1_data = 32'h7654_3210; rs2_data = 32'h8765_4321; rd_in = 5'd17;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midreset_busy",   32'(busy),   32'd0);
        check("midreset_done",   32'(done),   32'd0);
        check("midreset_result", result,      32'd0);
        check("midreset_rd_out", 32'(rd_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        expect_quiet("midreset_no_done", 40);
        run_op(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd21, res, rtag, lat);
        check("post_reset_result",  res,       model(3'b100, 32'hFFFF_FF9C, 32'd7));
        check("post_reset_rd_out",  32'(rtag), 32'd21);
        check("post_reset_latency", 32'(lat),  32'(LAT_NORMAL));

        // randomized back-to-back ops against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            logic [4:0]  tag;
            int          mode;
            f3   = 3'($urandom);
            a    = $urandom;
            b    = $urandom;
            tag  = 5'($urandom);
            mode = int'($urandom_range(0, 9));
            if (mode == 0) b = 32'd0;
            if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (mode == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
            if (mode == 3) b = 32'hFFFF_FFFF;
            run_op(f3, a, b, tag, res, rtag, lat);
            check($sformatf("rand%0d_f3_%0d_result", i, f3), res, model(f3, a, b));
            check($sformatf("rand%0d_rd_out", i), 32'(rtag), 32'(tag));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(model_lat(f3, a, b)));
        end

        @(posedge clk); #1;
        check("final_idle_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
